// File: rtl/pipeline_defines.sv
// Shared pipeline definitions used by the ID decoder, EX stage and MEM stage.
//   - dm_rd_ctrl / dm_wr_ctrl encodings for loads and stores
//   - MEM-stage bus FSM state type
//   - mem_fault(): misalignment / illegal-combination check for a memory op
package pipeline_defines;

    // Load types carried on dm_rd_ctrl
    localparam logic [2:0] DM_RD_NONE = 3'd0;
    localparam logic [2:0] DM_LB      = 3'd1;
    localparam logic [2:0] DM_LBU     = 3'd2;
    localparam logic [2:0] DM_LH      = 3'd3;
    localparam logic [2:0] DM_LHU     = 3'd4;
    localparam logic [2:0] DM_LW      = 3'd5;
    localparam logic [2:0] DM_LWU     = 3'd6;
    localparam logic [2:0] DM_LD      = 3'd7;

    // Store types carried on dm_wr_ctrl; 5..7 are illegal
    localparam logic [2:0] DM_WR_NONE = 3'd0;
    localparam logic [2:0] DM_SB      = 3'd1;
    localparam logic [2:0] DM_SH      = 3'd2;
    localparam logic [2:0] DM_SW      = 3'd3;
    localparam logic [2:0] DM_SD      = 3'd4;

    // MEM-stage bus FSM
    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,   // no access outstanding
        MEM_WAIT = 2'd1,   // request issued, waiting for dm_ack
        MEM_HOLD = 2'd2    // data returned while pipeline stalled, buffered
    } mem_state_t;

    // A memory op faults when its offset is not naturally aligned for its
    // size, when it is both a load and a store, or when the store type is
    // one of the unused encodings.
    function automatic logic mem_fault(input logic [2:0] rd_ctrl,
                                       input logic [2:0] wr_ctrl,
                                       input logic [2:0] off);
        logic f;
        f = (rd_ctrl != DM_RD_NONE) && (wr_ctrl != DM_WR_NONE);
        case (rd_ctrl)
            DM_LH, DM_LHU: f |= (off[0] != 1'b0);
            DM_LW, DM_LWU: f |= (off[1:0] != 2'b00);
            DM_LD:         f |= (off != 3'b000);
            default:       ;
        endcase
        case (wr_ctrl)
            DM_SH:             f |= (off[0] != 1'b0);
            DM_SW:             f |= (off[1:0] != 2'b00);
            DM_SD:             f |= (off != 3'b000);
            3'd5, 3'd6, 3'd7:  f = 1'b1;
            default:           ;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment for the 64-bit data-memory bus (purely combinational).
//   off        in   byte offset within the doubleword
//   rd_ctrl    in   load type
//   wr_ctrl    in   store type
//   store_data in   store source register value
//   rdata      in   doubleword returned by memory
//   wdata      out  store data replicated across all lanes of its size
//   wstrb      out  byte write strobes (0 when not a legal store type)
//   load_data  out  extracted and sign/zero-extended load value (0 if not a load)
module mem_lane_align
    import pipeline_defines::*;
(
    input  logic [2:0]  off,
    input  logic [2:0]  rd_ctrl,
    input  logic [2:0]  wr_ctrl,
    input  logic [63:0] store_data,
    input  logic [63:0] rdata,
    output logic [63:0] wdata,
    output logic [7:0]  wstrb,
    output logic [63:0] load_data
);

    // Addressed byte moved down to lane 0
    logic [63:0] lane;
    assign lane = rdata >> {off, 3'b000};

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        wdata = store_data;
        wstrb = 8'h00;
        case (wr_ctrl)
            DM_SB: begin
                wdata = {8{store_data[7:0]}};
                wstrb = 8'h01 << off;
            end
            DM_SH: begin
                wdata = {4{store_data[15:0]}};
                wstrb = 8'h03 << off;
            end
            DM_SW: begin
                wdata = {2{store_data[31:0]}};
                wstrb = 8'h0F << off;
            end
            DM_SD:   wstrb = 8'hFF;
            default: ;
        endcase
    end

    always_comb begin
        load_data = '0;
        case (rd_ctrl)
            DM_LB:   load_data = {{56{lane[7]}},  lane[7:0]};
            DM_LBU:  load_data = {56'd0,          lane[7:0]};
            DM_LH:   load_data = {{48{lane[15]}}, lane[15:0]};
            DM_LHU:  load_data = {48'd0,          lane[15:0]};
            DM_LW:   load_data = {{32{lane[31]}}, lane[31:0]};
            DM_LWU:  load_data = {32'd0,          lane[31:0]};
            DM_LD:   load_data = lane;
            default: ;
        endcase
    end

endmodule

// File: rtl/pipeline_mem_stage.sv
// Memory-access stage of the 5-stage RV64 pipeline.
// Issues one req/ack transaction per load/store, formats lanes, flags
// misaligned/illegal ops, and drives the registered MEM/WB register.
//   clk, reset            clock, asynchronous active-low reset
//   stall_in              stall from the hazard unit (does not include mem_stall)
//   alu_result_EX, pc_MEM, reg_data2_MEM, rd_MEM,
//   rf_wr_en_EX, rf_wr_sel_EX, dm_rd_ctrl_EX, dm_wr_ctrl_EX   EX/MEM register
//   dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb, dm_ack, dm_rdata  data bus
//   mem_stall             freezes IF..MEM while an access is outstanding
//   *_WB                  registered MEM/WB outputs
module pipeline_mem_stage
    import pipeline_defines::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_in,
    input  logic [XLEN-1:0] alu_result_EX,
    input  logic [XLEN-1:0] pc_MEM,
    input  logic [XLEN-1:0] reg_data2_MEM,
    input  logic [4:0]      rd_MEM,
    input  logic            rf_wr_en_EX,
    input  logic [1:0]      rf_wr_sel_EX,
    input  logic [2:0]      dm_rd_ctrl_EX,
    input  logic [2:0]      dm_wr_ctrl_EX,
    output logic            dm_req,
    output logic            dm_we,
    output logic [XLEN-1:0] dm_addr,
    output logic [XLEN-1:0] dm_wdata,
    output logic [7:0]      dm_wstrb,
    input  logic            dm_ack,
    input  logic [XLEN-1:0] dm_rdata,
    output logic            mem_stall,
    output logic [XLEN-1:0] pc_WB,
    output logic [XLEN-1:0] alu_result_WB,
    output logic [XLEN-1:0] mem_data_WB,
    output logic [4:0]      rd_WB,
    output logic            rf_wr_en_WB,
    output logic [1:0]      rf_wr_sel_WB,
    output logic            misalign_WB
);

    logic [2:0]      off;
    logic            fault;
    logic            access;
    mem_state_t      state, state_next;
    logic            buf_load;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] load_buf;
    logic [XLEN-1:0] mem_data_cap;

    assign off    = alu_result_EX[2:0];
    assign fault  = mem_fault(dm_rd_ctrl_EX, dm_wr_ctrl_EX, off);
    assign access = ((dm_rd_ctrl_EX != DM_RD_NONE) || (dm_wr_ctrl_EX != DM_WR_NONE)) && !fault;

    // Address, direction and lane data are pure functions of the frozen
    // EX/MEM register, so they stay stable for as long as dm_req is held.
    assign dm_addr = {alu_result_EX[XLEN-1:3], 3'b000};
    assign dm_we   = (dm_wr_ctrl_EX != DM_WR_NONE);

    mem_lane_align u_align (
        .off        (off),
        .rd_ctrl    (dm_rd_ctrl_EX),
        .wr_ctrl    (dm_wr_ctrl_EX),
        .store_data (reg_data2_MEM),
        .rdata      (dm_rdata),
        .wdata      (dm_wdata),
        .wstrb      (dm_wstrb),
        .load_data  (load_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the values from before the edge.
        if (!reset) state <= MEM_IDLE;
        else        state <= state_next;
    end

    // dm_ack is only honoured while dm_req is high; a spurious ack in HOLD or
    // with no access pending falls through without effect.
    always_comb begin
        state_next = state;
        dm_req     = 1'b0;
        mem_stall  = 1'b0;
        buf_load   = 1'b0;
        case (state)
            MEM_IDLE, MEM_WAIT: begin
                dm_req    = access;
                mem_stall = access && !dm_ack;
                if (access && dm_ack) begin
                    if (stall_in) begin
                        buf_load   = 1'b1;
                        state_next = MEM_HOLD;
                    end else begin
                        state_next = MEM_IDLE;
                    end
                end else if (access) begin
                    state_next = MEM_WAIT;
                end else begin
                    state_next = MEM_IDLE;
                end
            end
            MEM_HOLD: begin
                mem_stall = stall_in;
                if (!stall_in) state_next = MEM_IDLE;
            end
            default: state_next = MEM_IDLE;
        endcase
    end

    // Data returned during a pipeline stall is replayed from the buffer.
    assign mem_data_cap = !access             ? '0 :
                          (state == MEM_HOLD) ? load_buf : load_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_WB         <= '0;
            alu_result_WB <= '0;
            mem_data_WB   <= '0;
            rd_WB         <= '0;
            rf_wr_en_WB   <= 1'b0;
            rf_wr_sel_WB  <= '0;
            misalign_WB   <= 1'b0;
            // NOTE: the load buffer is a single register, not a memory array,
            // so it is cleared by reset along with the rest of the state.
            load_buf      <= '0;
        end else begin
            if (buf_load) load_buf <= load_data;
            if (!stall_in) begin
                if (mem_stall) begin
                    // Bubble: WB must not commit anything while waiting
                    rf_wr_en_WB <= 1'b0;
                    rd_WB       <= '0;
                    misalign_WB <= 1'b0;
                end else begin
                    pc_WB         <= pc_MEM;
                    alu_result_WB <= alu_result_EX;
                    mem_data_WB   <= mem_data_cap;
                    rd_WB         <= rd_MEM;
                    rf_wr_en_WB   <= rf_wr_en_EX && !fault;
                    rf_wr_sel_WB  <= rf_wr_sel_EX;
                    misalign_WB   <= fault;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipeline_mem_stage.sv
// Directed self-checking bench for pipeline_mem_stage.
// Inputs change on the falling edge; combinational outputs are sampled 1 ns
// later, registered outputs 1 ns after the rising edge.
module tb_pipeline_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_in;
    logic [63:0] alu_result_EX, pc_MEM, reg_data2_MEM;
    logic [4:0]  rd_MEM;
    logic        rf_wr_en_EX;
    logic [1:0]  rf_wr_sel_EX;
    logic [2:0]  dm_rd_ctrl_EX, dm_wr_ctrl_EX;
    logic        dm_req, dm_we, dm_ack, mem_stall;
    logic [63:0] dm_addr, dm_wdata, dm_rdata;
    logic [7:0]  dm_wstrb;
    logic [63:0] pc_WB, alu_result_WB, mem_data_WB;
    logic [4:0]  rd_WB;
    logic        rf_wr_en_WB, misalign_WB;
    logic [1:0]  rf_wr_sel_WB;

    int n_pass  = 0;
    int n_total = 0;

    pipeline_mem_stage #(.XLEN(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall_in      (stall_in),
        .alu_result_EX (alu_result_EX),
        .pc_MEM        (pc_MEM),
        .reg_data2_MEM (reg_data2_MEM),
        .rd_MEM        (rd_MEM),
        .rf_wr_en_EX   (rf_wr_en_EX),
        .rf_wr_sel_EX  (rf_wr_sel_EX),
        .dm_rd_ctrl_EX (dm_rd_ctrl_EX),
        .dm_wr_ctrl_EX (dm_wr_ctrl_EX),
        .dm_req        (dm_req),
        .dm_we         (dm_we),
        .dm_addr       (dm_addr),
        .dm_wdata      (dm_wdata),
        .dm_wstrb      (dm_wstrb),
        .dm_ack        (dm_ack),
        .dm_rdata      (dm_rdata),
        .mem_stall     (mem_stall),
        .pc_WB         (pc_WB),
        .alu_result_WB (alu_result_WB),
        .mem_data_WB   (mem_data_WB),
        .rd_WB         (rd_WB),
        .rf_wr_en_WB   (rf_wr_en_WB),
        .rf_wr_sel_WB  (rf_wr_sel_WB),
        .misalign_WB   (misalign_WB)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic clear_inputs();
        stall_in = 0; alu_result_EX = '0; pc_MEM = '0; reg_data2_MEM = '0;
        rd_MEM = '0; rf_wr_en_EX = 0; rf_wr_sel_EX = '0;
        dm_rd_ctrl_EX = '0; dm_wr_ctrl_EX = '0; dm_ack = 0; dm_rdata = '0;
    endtask

    // Zero-wait memory op driven on the falling edge (stimulus only)
    task automatic drive_op(input logic [63:0] addr, input logic [2:0] rdc,
                            input logic [2:0] wrc, input logic [63:0] sdata,
                            input logic [63:0] rdata);
        @(negedge clk);
        clear_inputs();
        alu_result_EX = addr; dm_rd_ctrl_EX = rdc; dm_wr_ctrl_EX = wrc;
        reg_data2_MEM = sdata; dm_rdata = rdata; dm_ack = 1;
        rd_MEM = 5'd1; rf_wr_en_EX = (rdc != 0);
        #1;
    endtask

    task automatic test_reset();
        reset = 0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (dm_req !== 1'b0) $display("FAIL rst_req: got %0h want 0", dm_req); else n_pass++;
        n_total++; if (mem_stall !== 1'b0) $display("FAIL rst_stall: got %0h want 0", mem_stall); else n_pass++;
        n_total++; if ({pc_WB, alu_result_WB, mem_data_WB} !== '0) $display("FAIL rst_wb_data: got %0h want 0", {pc_WB, alu_result_WB, mem_data_WB}); else n_pass++;
        n_total++; if ({rd_WB, rf_wr_en_WB, rf_wr_sel_WB, misalign_WB} !== '0) $display("FAIL rst_wb_ctrl: got %0h want 0", {rd_WB, rf_wr_en_WB, rf_wr_sel_WB, misalign_WB}); else n_pass++;
        @(negedge clk);
        reset = 1;
    endtask

    task automatic test_zero_wait_lw();
        @(negedge clk);
        clear_inputs();
        pc_MEM = 64'h100; alu_result_EX = 64'h1004; dm_rd_ctrl_EX = 3'd5;  // LW
        rd_MEM = 5'd7; rf_wr_en_EX = 1; rf_wr_sel_EX = 2'd1;
        dm_ack = 1; dm_rdata = 64'h80000001_00000000;
        #1;
        n_total++; if (dm_req !== 1'b1) $display("FAIL lw_req: got %0h want 1", dm_req); else n_pass++;
        n_total++; if (dm_addr !== 64'h1000) $display("FAIL lw_addr: got %0h want 1000", dm_addr); else n_pass++;
        n_total++; if ({dm_we, dm_wstrb} !== 9'h000) $display("FAIL lw_we_strb: got %0h want 0", {dm_we, dm_wstrb}); else n_pass++;
        n_total++; if (mem_stall !== 1'b0) $display("FAIL lw_stall: got %0h want 0", mem_stall); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (mem_data_WB !== 64'hFFFFFFFF_80000001) $display("FAIL lw_data: got %0h want ffffffff80000001", mem_data_WB); else n_pass++;
        n_total++; if ({rf_wr_en_WB, rd_WB, rf_wr_sel_WB, misalign_WB} !== {1'b1, 5'd7, 2'd1, 1'b0}) $display("FAIL lw_ctrl: got %0h want %0h", {rf_wr_en_WB, rd_WB, rf_wr_sel_WB, misalign_WB}, {1'b1, 5'd7, 2'd1, 1'b0}); else n_pass++;
        n_total++; if ({pc_WB, alu_result_WB} !== {64'h100, 64'h1004}) $display("FAIL lw_pc_alu: got %0h want %0h", {pc_WB, alu_result_WB}, {64'h100, 64'h1004}); else n_pass++;
    endtask

    task automatic test_sb_wait();
        @(negedge clk);
        clear_inputs();
        pc_MEM = 64'h200; alu_result_EX = 64'h2003; dm_wr_ctrl_EX = 3'd1;  // SB
        reg_data2_MEM = 64'h12345678_9ABCDEAB;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++; if ({dm_req, dm_we, mem_stall} !== 3'b111) $display("FAIL sb_wait%0d_req_we_stall: got %0b want 111", i, {dm_req, dm_we, mem_stall}); else n_pass++;
            n_total++; if ({dm_addr, dm_wstrb} !== {64'h2000, 8'h08}) $display("FAIL sb_wait%0d_addr_strb: got %0h want %0h", i, {dm_addr, dm_wstrb}, {64'h2000, 8'h08}); else n_pass++;
            n_total++; if (dm_wdata !== 64'hABABABAB_ABABABAB) $display("FAIL sb_wait%0d_wdata: got %0h want abababababababab", i, dm_wdata); else n_pass++;
            @(posedge clk); #1;
            n_total++; if ({rf_wr_en_WB, rd_WB, misalign_WB} !== 7'd0) $display("FAIL sb_wait%0d_bubble: got %0h want 0", i, {rf_wr_en_WB, rd_WB, misalign_WB}); else n_pass++;
            @(negedge clk);
        end
        dm_ack = 1;
        #1;
        n_total++; if ({dm_req, mem_stall, dm_wstrb} !== {1'b1, 1'b0, 8'h08}) $display("FAIL sb_ack_cycle: got %0h want %0h", {dm_req, mem_stall, dm_wstrb}, {1'b1, 1'b0, 8'h08}); else n_pass++;
        @(posedge clk); #1;
        n_total++; if ({pc_WB, alu_result_WB} !== {64'h200, 64'h2003}) $display("FAIL sb_capture: got %0h want %0h", {pc_WB, alu_result_WB}, {64'h200, 64'h2003}); else n_pass++;
        n_total++; if ({mem_data_WB, rf_wr_en_WB, misalign_WB} !== '0) $display("FAIL sb_wb_ctrl: got %0h want 0", {mem_data_WB, rf_wr_en_WB, misalign_WB}); else n_pass++;
    endtask

    task automatic test_misalign_lhu();
        @(negedge clk);
        clear_inputs();
        alu_result_EX = 64'h3001; dm_rd_ctrl_EX = 3'd4;  // LHU
        rd_MEM = 5'd9; rf_wr_en_EX = 1; dm_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        n_total++; if ({dm_req, mem_stall} !== 2'b00) $display("FAIL lhu_req_stall: got %0b want 00", {dm_req, mem_stall}); else n_pass++;
        @(posedge clk); #1;
        n_total++; if ({misalign_WB, rf_wr_en_WB} !== 2'b10) $display("FAIL lhu_fault: got %0b want 10", {misalign_WB, rf_wr_en_WB}); else n_pass++;
        n_total++; if ({alu_result_WB, mem_data_WB} !== {64'h3001, 64'h0}) $display("FAIL lhu_wb_data: got %0h want %0h", {alu_result_WB, mem_data_WB}, {64'h3001, 64'h0}); else n_pass++;
    endtask

    task automatic test_hold_lbu();
        @(negedge clk);
        clear_inputs();
        alu_result_EX = 64'h4005; dm_rd_ctrl_EX = 3'd2;  // LBU, byte 5
        rd_MEM = 5'd3; rf_wr_en_EX = 1; rf_wr_sel_EX = 2'd1;
        stall_in = 1; dm_ack = 1; dm_rdata = 64'h1122F044_55667788;
        #1;
        n_total++; if ({dm_req, mem_stall, dm_addr} !== {1'b1, 1'b0, 64'h4000}) $display("FAIL lbu_req: got %0h want %0h", {dm_req, mem_stall, dm_addr}, {1'b1, 1'b0, 64'h4000}); else n_pass++;
        @(posedge clk); #1;
        n_total++; if ({alu_result_WB, misalign_WB} !== {64'h3001, 1'b1}) $display("FAIL lbu_hold1: got %0h want %0h", {alu_result_WB, misalign_WB}, {64'h3001, 1'b1}); else n_pass++;
        @(negedge clk);
        dm_ack = 0; dm_rdata = '0;
        #1;
        n_total++; if ({dm_req, mem_stall} !== 2'b01) $display("FAIL lbu_hold_state: got %0b want 01", {dm_req, mem_stall}); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (alu_result_WB !== 64'h3001) $display("FAIL lbu_hold2: got %0h want 3001", alu_result_WB); else n_pass++;
        @(negedge clk);
        stall_in = 0;
        #1;
        n_total++; if ({dm_req, mem_stall} !== 2'b00) $display("FAIL lbu_release: got %0b want 00", {dm_req, mem_stall}); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (mem_data_WB !== 64'hF0) $display("FAIL lbu_data: got %0h want f0", mem_data_WB); else n_pass++;
        n_total++; if ({rf_wr_en_WB, rd_WB, misalign_WB, alu_result_WB} !== {1'b1, 5'd3, 1'b0, 64'h4005}) $display("FAIL lbu_ctrl: got %0h want %0h", {rf_wr_en_WB, rd_WB, misalign_WB, alu_result_WB}, {1'b1, 5'd3, 1'b0, 64'h4005}); else n_pass++;
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        clear_inputs();
        alu_result_EX = 64'h5008; dm_rd_ctrl_EX = 3'd7;  // LD
        rd_MEM = 5'd4; rf_wr_en_EX = 1; pc_MEM = 64'h500;
        @(posedge clk);
        @(negedge clk); #1;
        n_total++; if ({dm_req, mem_stall} !== 2'b11) $display("FAIL rstwait_pending: got %0b want 11", {dm_req, mem_stall}); else n_pass++;
        reset = 0;
        clear_inputs();
        #1;
        n_total++; if ({dm_req, mem_stall} !== 2'b00) $display("FAIL rstwait_req_stall: got %0b want 00", {dm_req, mem_stall}); else n_pass++;
        n_total++; if ({pc_WB, alu_result_WB, mem_data_WB} !== '0) $display("FAIL rstwait_wb_data: got %0h want 0", {pc_WB, alu_result_WB, mem_data_WB}); else n_pass++;
        n_total++; if ({rd_WB, rf_wr_en_WB, rf_wr_sel_WB, misalign_WB} !== '0) $display("FAIL rstwait_wb_ctrl: got %0h want 0", {rd_WB, rf_wr_en_WB, rf_wr_sel_WB, misalign_WB}); else n_pass++;
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        alu_result_EX = 64'h6000; dm_rd_ctrl_EX = 3'd7; rd_MEM = 5'd4; rf_wr_en_EX = 1;
        dm_ack = 1; dm_rdata = 64'h01234567_89ABCDEF;
        #1;
        n_total++; if ({dm_req, mem_stall} !== 2'b10) $display("FAIL ld_after_rst_req: got %0b want 10", {dm_req, mem_stall}); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (mem_data_WB !== 64'h01234567_89ABCDEF) $display("FAIL ld_after_rst_data: got %0h want 123456789abcdef", mem_data_WB); else n_pass++;
        n_total++; if ({rf_wr_en_WB, rd_WB, alu_result_WB} !== {1'b1, 5'd4, 64'h6000}) $display("FAIL ld_after_rst_ctrl: got %0h want %0h", {rf_wr_en_WB, rd_WB, alu_result_WB}, {1'b1, 5'd4, 64'h6000}); else n_pass++;
    endtask

    task automatic test_illegal_ctrl();
        @(negedge clk);
        clear_inputs();
        alu_result_EX = 64'h7000; dm_rd_ctrl_EX = 3'd7; dm_wr_ctrl_EX = 3'd4;  // LD+SD
        rd_MEM = 5'd5; rf_wr_en_EX = 1;
        #1;
        n_total++; if ({dm_req, mem_stall} !== 2'b00) $display("FAIL both_req: got %0b want 00", {dm_req, mem_stall}); else n_pass++;
        @(posedge clk); #1;
        n_total++; if ({misalign_WB, rf_wr_en_WB} !== 2'b10) $display("FAIL both_fault: got %0b want 10", {misalign_WB, rf_wr_en_WB}); else n_pass++;
        @(negedge clk);
        clear_inputs();
        @(posedge clk); #1;
        n_total++; if (misalign_WB !== 1'b0) $display("FAIL nop_clears_fault: got %0h want 0", misalign_WB); else n_pass++;
        @(negedge clk);
        alu_result_EX = 64'h7008; dm_wr_ctrl_EX = 3'd5;  // illegal store type
        #1;
        n_total++; if (dm_req !== 1'b0) $display("FAIL wr5_req: got %0h want 0", dm_req); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (misalign_WB !== 1'b1) $display("FAIL wr5_fault: got %0h want 1", misalign_WB); else n_pass++;
    endtask

    task automatic test_formats();
        drive_op(64'h806, 3'd0, 3'd2, 64'h0000_0000_0000_BEEF, '0);  // SH off 6
        n_total++; if ({dm_wstrb, dm_wdata} !== {8'hC0, 64'hBEEFBEEF_BEEFBEEF}) $display("FAIL sh_fmt: got %0h want %0h", {dm_wstrb, dm_wdata}, {8'hC0, 64'hBEEFBEEF_BEEFBEEF}); else n_pass++;
        drive_op(64'h804, 3'd0, 3'd3, 64'h11111111_DEADBEEF, '0);  // SW off 4
        n_total++; if ({dm_wstrb, dm_wdata} !== {8'hF0, 64'hDEADBEEF_DEADBEEF}) $display("FAIL sw_fmt: got %0h want %0h", {dm_wstrb, dm_wdata}, {8'hF0, 64'hDEADBEEF_DEADBEEF}); else n_pass++;
        drive_op(64'h808, 3'd0, 3'd4, 64'hCAFEF00D_12345678, '0);  // SD
        n_total++; if ({dm_wstrb, dm_wdata} !== {8'hFF, 64'hCAFEF00D_12345678}) $display("FAIL sd_fmt: got %0h want %0h", {dm_wstrb, dm_wdata}, {8'hFF, 64'hCAFEF00D_12345678}); else n_pass++;
        drive_op(64'h807, 3'd1, 3'd0, '0, 64'h80000000_00000000);  // LB off 7
        @(posedge clk); #1;
        n_total++; if (mem_data_WB !== 64'hFFFFFFFF_FFFFFF80) $display("FAIL lb_fmt: got %0h want ffffffffffffff80", mem_data_WB); else n_pass++;
        drive_op(64'h802, 3'd3, 3'd0, '0, 64'h00000000_80010000);  // LH off 2
        @(posedge clk); #1;
        n_total++; if (mem_data_WB !== 64'hFFFFFFFF_FFFF8001) $display("FAIL lh_fmt: got %0h want ffffffffffff8001", mem_data_WB); else n_pass++;
        drive_op(64'h804, 3'd6, 3'd0, '0, 64'h80000001_00000000);  // LWU off 4
        @(posedge clk); #1;
        n_total++; if (mem_data_WB !== 64'h00000000_80000001) $display("FAIL lwu_fmt: got %0h want 80000001", mem_data_WB); else n_pass++;
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_zero_wait_lw();
        test_sb_wait();
        test_misalign_lhu();
        test_hold_lbu();
        test_reset_in_wait();
        test_illegal_ctrl();
        test_formats();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
